ram_port_b_arbiter: RTL

Shares the read-only port B (address / q_b) of the processor's byte-wide data RAM among several external readers, such as the display scanner and the debug/UART dump engine. The block does round-robin arbitration with a one-cycle request/grant handshake and pipelines a tag for each accepted read. It then returns the RAM byte to the winning requester exactly RD_LAT cycles later. It sits between the `arm` top level's external read port and the peripheral readers. The CPU data port (port A) is not touched.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_port_b_arbiter_rr_pick.sv | 37 +++
 rtl/ram_port_b_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data-RAM port-B arbiter.
// Constants here match the RAM instantiation in the arm top level.
package ram_arb_pkg;

    localparam int NREQ_MAX          = 8;
    localparam int ID_W              = $clog2(NREQ_MAX);
    localparam int DEF_MEM_BYTES     = 256;
    localparam int DEF_RD_LAT        = 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    oob;
    } rd_tag_t;

endpackage

// File: rtl/ram_port_b_arbiter_rr_pick.sv
// Combinational round-robin picker: searches cyclically from last+1.
// Reusable by any shared resource needing a fair one-hot grant.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  req_id_t         last,
    output logic [NREQ-1:0] gnt,
    output req_id_t         id,
    output logic            found
);

    // First requester after last, wrapping around, wins.
    always_comb begin
        found = 1'b0;
        id    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && ((int'(last) + k) % NREQ) == j) begin
                    found = 1'b1;
                    id    = req_id_t'(j);
                end
            end
        end
    end

    // Expand winner id to a one-hot grant vector.
    always_comb begin
        gnt = '0;
        for (int j = 0; j < NREQ; j++) begin
            gnt[j] = found && (id == req_id_t'(j));
        end
    end

endmodule

// File: rtl/ram_port_b_arbiter.sv
// Round-robin arbiter sharing data-RAM port B among external readers,
// returning each byte to its requester RD_LAT cycles after the grant.
module ram_port_b_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   oob,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_q
);

    localparam logic [ADDR_W-1:0] MEM_LIM = ADDR_W'(MEM_BYTES);

    req_id_t           last;
    req_id_t           win_id;
    logic [NREQ-1:0]   pick_gnt;
    logic              found;
    logic              any_gnt;
    logic              in_range;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] addr_q;
    rd_tag_t           tags [RD_LAT];
    rd_tag_t           tail;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req & {NREQ{en}}),
        .last  (last),
        .gnt   (pick_gnt),
        .id    (win_id),
        .found (found)
    );

    // Grant only outside reset; en is already folded into the picker.
    always_comb begin
        any_gnt = found && !rst;
        gnt     = rst ? '0 : pick_gnt;
    end

    // Select the winner's address and classify it against the RAM size.
    always_comb begin
        win_addr = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win_id == req_id_t'(j)) begin
                win_addr = req_addr[j*ADDR_W +: ADDR_W];
            end
        end
        in_range = win_addr < MEM_LIM;
        mem_addr = (any_gnt && in_range) ? win_addr : addr_q;
    end

    // Round-robin pointer and idle-stable address copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last   <= req_id_t'(NREQ - 1);
            addr_q <= '0;
        end else if (any_gnt) begin
            last <= win_id;
            if (in_range) begin
                addr_q <= win_addr;
            end
        end
    end

    // Tag pipeline tracks each accepted read until its data returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0].valid <= any_gnt;
            tags[0].id    <= win_id;
            tags[0].oob   <= !in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    // Route the returning byte to its requester; zero when idle or out of range.
    always_comb begin
        tail   = tags[RD_LAT-1];
        rvalid = '0;
        for (int j = 0; j < NREQ; j++) begin
            rvalid[j] = tail.valid && (tail.id == req_id_t'(j));
        end
        oob   = tail.valid && tail.oob;
        rdata = (tail.valid && !tail.oob) ? mem_q : '0;
    end

endmodule
